// File: rtl/scoreboard_pkg.sv
// Shared types and default geometry for the issue-side register scoreboard.
package scoreboard_pkg;

  localparam int GLB_REG_NUM = 32;
  localparam int SB_NREGS    = GLB_REG_NUM + 1;
  localparam int SB_RIDX_W   = $clog2(SB_NREGS);
  localparam int SB_CNT_W    = 2;
  localparam int SB_INF_W    = 4;
  localparam int SB_NSRC     = 3;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_DRAIN,
    ST_HOLD
  } sb_state_e;

  // Issue request as assembled from micro_op_t by the data-fetch stage.
  typedef struct packed {
    logic [SB_NSRC-1:0]                src_v;
    logic [SB_NSRC-1:0][SB_RIDX_W-1:0] src;
    logic                              dst_v;
    logic [SB_RIDX_W-1:0]              dst;
    logic                              serialize;
  } sb_issue_t;

endpackage

// File: rtl/sb_counter_bank.sv
// Bank of saturating in-flight writer counters, one increment and one decrement port.
module sb_counter_bank #(
  parameter int NREGS  = 33,
  parameter int RIDX_W = 6,
  parameter int CNT_W  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              inc_en,
  input  logic [RIDX_W-1:0] inc_idx,
  input  logic              dec_en,
  input  logic [RIDX_W-1:0] dec_idx,
  output logic [NREGS-1:0]  busy_vec,
  output logic [NREGS-1:0]  at_max_vec
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  for (genvar gi = 0; gi < NREGS; gi++) begin : g_cnt
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             inc, dec;

    assign inc = inc_en && (inc_idx == RIDX_W'(gi));
    assign dec = dec_en && (dec_idx == RIDX_W'(gi));

    // Simultaneous inc and dec on the same register cancel out.
    always_comb begin
      cnt_d = cnt_q;
      if (clr)                                     cnt_d = '0;
      else if (inc && !dec && cnt_q != CNT_MAX)    cnt_d = cnt_q + CNT_W'(1);
      else if (dec && !inc && cnt_q != '0)         cnt_d = cnt_q - CNT_W'(1);
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) cnt_q <= '0;
      else        cnt_q <= cnt_d;
    end

    assign busy_vec[gi]   = (cnt_q != '0);
    assign at_max_vec[gi] = (cnt_q == CNT_MAX);
  end

endmodule

// File: rtl/reg_scoreboard.sv
// Register scoreboard: gates decode-to-fetch handoff on RAW/WAW hazards, tracks
// in-flight uops, serializes syscall-like uops and supports a full flush.
module reg_scoreboard
  import scoreboard_pkg::*;
#(
  parameter int NREGS  = SB_NREGS,
  parameter int RIDX_W = SB_RIDX_W,
  parameter int CNT_W  = SB_CNT_W,
  parameter int INF_W  = SB_INF_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  iss_valid,
  input  logic [2:0]            iss_src_v,
  input  logic [3*RIDX_W-1:0]   iss_src,
  input  logic                  iss_dst_v,
  input  logic [RIDX_W-1:0]     iss_dst,
  input  logic                  iss_serialize,
  output logic                  iss_ready,
  input  logic                  wb_valid,
  input  logic                  wb_dst_v,
  input  logic [RIDX_W-1:0]     wb_dst,
  input  logic                  ser_done,
  input  logic                  flush,
  output logic [NREGS-1:0]      busy_vec,
  output logic [INF_W-1:0]      inflight,
  output logic [31:0]           stall_cnt,
  output logic                  err
);

  localparam int               NIDX    = 1 << RIDX_W;
  localparam logic [INF_W-1:0] INF_MAX = '1;

  sb_state_e        state_q, state_d;
  logic [INF_W-1:0] inflight_q, inflight_d;
  logic [31:0]      stall_cnt_q, stall_cnt_d;
  logic             err_q, err_d;

  logic [NREGS-1:0] at_max_vec;
  logic [NIDX-1:0]  busy_ext, at_max_ext;
  logic [2:0]       src_hit, src_oob;
  logic             dst_oob, wb_oob, hazard_ok, ready, fire;
  logic             inc_en, dec_en, same_reg, wb_under, inf_under;

  // Zero-extended to the full index space so out-of-range indices read as idle.
  assign busy_ext   = NIDX'(busy_vec);
  assign at_max_ext = NIDX'(at_max_vec);

  for (genvar gi = 0; gi < 3; gi++) begin : g_src
    logic [RIDX_W-1:0] idx;
    assign idx         = iss_src[gi*RIDX_W +: RIDX_W];
    assign src_oob[gi] = iss_src_v[gi] && (32'(idx) >= NREGS);
    assign src_hit[gi] = iss_src_v[gi] && busy_ext[idx];
  end

  assign dst_oob   = iss_dst_v && (32'(iss_dst) >= NREGS);
  assign wb_oob    = wb_dst_v && (32'(wb_dst) >= NREGS);
  assign hazard_ok = !(|src_hit) && !(iss_dst_v && at_max_ext[iss_dst]) && (inflight_q != INF_MAX);

  always_comb begin
    ready = 1'b0;
    if (reset && !flush) begin
      unique case (state_q)
        ST_RUN:   ready = hazard_ok && !iss_serialize;
        ST_DRAIN: ready = hazard_ok && (inflight_q == '0);
        default:  ready = 1'b0;
      endcase
    end
  end

  assign iss_ready = ready;
  assign fire      = iss_valid && ready;
  assign inc_en    = fire && iss_dst_v && !dst_oob;
  assign same_reg  = inc_en && wb_valid && wb_dst_v && (iss_dst == wb_dst);
  assign wb_under  = wb_valid && wb_dst_v && !wb_oob && !busy_ext[wb_dst] && !same_reg;
  assign dec_en    = wb_valid && wb_dst_v && !wb_oob && !wb_under && !flush;

  always_comb begin
    state_d = state_q;
    if (flush) state_d = ST_RUN;
    else begin
      unique case (state_q)
        ST_RUN:   if (iss_valid && iss_serialize) state_d = ST_DRAIN;
        ST_DRAIN: if (fire)                       state_d = ST_HOLD;
        ST_HOLD:  if (ser_done)                   state_d = ST_RUN;
        default:                                  state_d = ST_RUN;
      endcase
    end
  end

  always_comb begin
    inflight_d = inflight_q;
    inf_under  = 1'b0;
    if (flush)                   inflight_d = '0;
    else if (fire && !wb_valid)  inflight_d = inflight_q + INF_W'(1);
    else if (wb_valid && !fire) begin
      if (inflight_q == '0) inf_under  = 1'b1;
      else                  inflight_d = inflight_q - INF_W'(1);
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q + 32'(iss_valid && !ready);
    err_d       = err_q || (!flush && ((iss_valid && ((|src_oob) || dst_oob)) ||
                                       (wb_valid && wb_oob) || wb_under || inf_under ||
                                       (ser_done && state_q != ST_HOLD)));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_RUN;
      inflight_q  <= '0;
      stall_cnt_q <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      inflight_q  <= inflight_d;
      stall_cnt_q <= stall_cnt_d;
      err_q       <= err_d;
    end
  end

  sb_counter_bank #(
    .NREGS  (NREGS),
    .RIDX_W (RIDX_W),
    .CNT_W  (CNT_W)
  ) u_cnt_bank (
    .clk        (clk),
    .reset      (reset),
    .clr        (flush),
    .inc_en     (inc_en),
    .inc_idx    (iss_dst),
    .dec_en     (dec_en),
    .dec_idx    (wb_dst),
    .busy_vec   (busy_vec),
    .at_max_vec (at_max_vec)
  );

  assign inflight  = inflight_q;
  assign stall_cnt = stall_cnt_q;
  assign err       = err_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed scoreboard bench for reg_scoreboard: driver queues expectations, monitor checks at negedge.
module tb_reg_scoreboard;

  localparam int NR = 33;
  localparam int RW = 6;
  localparam int IW = 4;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            iss_valid, iss_dst_v, iss_serialize, iss_ready;
  logic [2:0]      iss_src_v;
  logic [3*RW-1:0] iss_src;
  logic [RW-1:0]   iss_dst, wb_dst;
  logic            wb_valid, wb_dst_v, ser_done, flush, err;
  logic [NR-1:0]   busy_vec;
  logic [IW-1:0]   inflight;
  logic [31:0]     stall_cnt;

  always #5 clk = ~clk;

  reg_scoreboard dut (
    .clk           (clk),
    .reset         (reset),
    .iss_valid     (iss_valid),
    .iss_src_v     (iss_src_v),
    .iss_src       (iss_src),
    .iss_dst_v     (iss_dst_v),
    .iss_dst       (iss_dst),
    .iss_serialize (iss_serialize),
    .iss_ready     (iss_ready),
    .wb_valid      (wb_valid),
    .wb_dst_v      (wb_dst_v),
    .wb_dst        (wb_dst),
    .ser_done      (ser_done),
    .flush         (flush),
    .busy_vec      (busy_vec),
    .inflight      (inflight),
    .stall_cnt     (stall_cnt),
    .err           (err)
  );

  typedef struct {
    int            cyc;
    string         name;
    logic          rdy;
    logic [NR-1:0] busy;
    logic [IW-1:0] inf;
    logic [31:0]   stall;
    logic          err;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_err = 0;

  logic [NR-1:0] e_busy;
  logic [IW-1:0] e_inf;
  logic [31:0]   e_stall;
  logic          e_err;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input string fld, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s.%s: got %h expected %h", nm, fld, act, exp);
    end
  endtask

  // Monitor: pops every expectation scheduled for this cycle and compares.
  always @(negedge clk) begin
    exp_t e;
    while (q.size() > 0 && q[0].cyc == cyc) begin
      e = q.pop_front();
      chk(e.name, "iss_ready", 64'(iss_ready), 64'(e.rdy));
      chk(e.name, "busy_vec",  64'(busy_vec),  64'(e.busy));
      chk(e.name, "inflight",  64'(inflight),  64'(e.inf));
      chk(e.name, "stall_cnt", 64'(stall_cnt), 64'(e.stall));
      chk(e.name, "err",       64'(err),       64'(e.err));
      $display("txn %-16s cyc=%0d ready=%b inflight=%0d busy=%h stall=%0d err=%b",
               e.name, cyc, iss_ready, inflight, busy_vec, stall_cnt, err);
    end
  end

  task automatic idle();
    iss_valid = 1'b0; iss_src_v = '0; iss_src = '0; iss_dst_v = 1'b0; iss_dst = '0;
    iss_serialize = 1'b0; wb_valid = 1'b0; wb_dst_v = 1'b0; wb_dst = '0;
    ser_done = 1'b0; flush = 1'b0;
  endtask

  task automatic issue(input logic [2:0] sv, input logic [RW-1:0] s1, input logic dv,
                       input logic [RW-1:0] d, input logic ser);
    iss_valid = 1'b1; iss_src_v = sv; iss_src = {{(2*RW){1'b0}}, s1};
    iss_dst_v = dv; iss_dst = d; iss_serialize = ser;
  endtask

  task automatic wbk(input logic dv, input logic [RW-1:0] d);
    wb_valid = 1'b1; wb_dst_v = dv; wb_dst = d;
  endtask

  // Queue the expectation for the current cycle, account for a stall, advance one clock.
  task automatic tick(input string name, input logic rdy);
    exp_t e;
    e.cyc = cyc; e.name = name; e.rdy = rdy; e.busy = e_busy;
    e.inf = e_inf; e.stall = e_stall; e.err = e_err;
    q.push_back(e);
    if (reset && iss_valid && !rdy) e_stall++;
    @(posedge clk); #1;
    idle();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    idle();
    e_busy = '0; e_inf = '0; e_stall = '0; e_err = 1'b0;
    @(posedge clk); #1;

    issue(3'b000, 0, 0, 0, 0); tick("rst_ready", 0);
    issue(3'b000, 0, 0, 0, 0); tick("rst_hold", 0);
    reset = 1'b1;

    // RAW with no writeback bypass
    issue(3'b000, 0, 1, 3, 0); tick("raw_issue", 1); e_busy[3] = 1'b1; e_inf = 1;
    issue(3'b001, 3, 0, 0, 0); tick("raw_block", 0);
    issue(3'b001, 3, 0, 0, 0); wbk(1, 3); tick("raw_wb_nobypass", 0); e_busy[3] = 1'b0; e_inf = 0;
    issue(3'b001, 3, 0, 0, 0); tick("raw_release", 1); e_inf = 1;
    wbk(0, 0); tick("raw_retire", 1); e_inf = 0;

    // WAW saturation on r7
    for (int i = 0; i < 3; i++) begin
      issue(3'b000, 0, 1, 7, 0); tick("waw_fill", 1); e_busy[7] = 1'b1; e_inf = e_inf + 1'b1;
    end
    issue(3'b000, 0, 1, 7, 0); tick("waw_sat", 0);
    issue(3'b000, 0, 1, 7, 0); tick("waw_sat", 0);
    issue(3'b000, 0, 1, 7, 0); wbk(1, 7); tick("waw_wb", 0); e_inf = 2;
    issue(3'b000, 0, 1, 7, 0); tick("waw_fire4", 1); e_inf = 3;
    for (int i = 0; i < 3; i++) begin
      wbk(1, 7); tick("waw_drain", 1); e_inf = e_inf - 1'b1;
    end
    e_busy[7] = 1'b0;

    // Same-cycle issue and writeback of r2
    issue(3'b000, 0, 1, 2, 0); tick("sim_issue", 1); e_busy[2] = 1'b1; e_inf = 1;
    issue(3'b000, 0, 1, 2, 0); wbk(1, 2); tick("sim_both", 1);
    wbk(1, 2); tick("sim_keep", 1); e_busy[2] = 1'b0; e_inf = 0;
    tick("sim_clear", 1);

    // Serialize: drain two in-flight, fire, hold until ser_done
    issue(3'b000, 0, 1, 10, 0); tick("ser_pre1", 1); e_busy[10] = 1'b1; e_inf = 1;
    issue(3'b000, 0, 1, 11, 0); tick("ser_pre2", 1); e_busy[11] = 1'b1; e_inf = 2;
    issue(3'b000, 0, 0, 0, 1); tick("ser_enter", 0);
    issue(3'b000, 0, 0, 0, 1); wbk(1, 10); tick("ser_drain2", 0); e_busy[10] = 1'b0; e_inf = 1;
    issue(3'b000, 0, 0, 0, 1); wbk(1, 11); tick("ser_drain1", 0); e_busy[11] = 1'b0; e_inf = 0;
    issue(3'b000, 0, 0, 0, 1); tick("ser_fire", 1); e_inf = 1;
    issue(3'b000, 0, 1, 5, 0); wbk(0, 0); tick("ser_hold", 0); e_inf = 0;
    issue(3'b000, 0, 1, 5, 0); ser_done = 1'b1; tick("ser_done", 0);
    issue(3'b000, 0, 1, 5, 0); tick("ser_run", 1); e_busy[5] = 1'b1; e_inf = 1;
    wbk(1, 5); tick("ser_retire", 1); e_busy[5] = 1'b0; e_inf = 0;

    // Flush with same-cycle fire and wb, then flush out of HOLD
    issue(3'b000, 0, 1, 4, 0); tick("fl_pre", 1); e_busy[4] = 1'b1; e_inf = 1;
    issue(3'b000, 0, 1, 4, 0); wbk(1, 4); flush = 1'b1; tick("fl_flush", 0); e_busy = '0; e_inf = 0;
    tick("fl_after", 1);
    issue(3'b000, 0, 0, 0, 1); tick("fl_ser_enter", 0);
    issue(3'b000, 0, 0, 0, 1); tick("fl_ser_fire", 1); e_inf = 1;
    flush = 1'b1; tick("fl_hold_flush", 0); e_inf = 0;
    tick("fl_run", 1);

    // Underflow on an idle register and empty pipeline
    wbk(1, 9); tick("err_under", 1); e_err = 1'b1;
    tick("err_sticky", 1);

    // Asynchronous reset while in HOLD
    issue(3'b000, 0, 0, 0, 1); tick("rh_enter", 0);
    issue(3'b000, 0, 0, 0, 1); tick("rh_fire", 1); e_inf = 1;
    issue(3'b000, 0, 1, 6, 0); tick("rh_hold", 0);
    reset = 1'b0;
    e_busy = '0; e_inf = 0; e_stall = 0; e_err = 1'b0;
    issue(3'b000, 0, 1, 6, 0); tick("rh_reset", 0);
    reset = 1'b1;

    // Out-of-range indices: source not busy, dst ignored, err set
    issue(3'b001, 40, 1, 50, 0); tick("oob_issue", 1); e_err = 1'b1; e_inf = 1;
    wbk(0, 0); tick("oob_check", 1); e_inf = 0;
    tick("oob_end", 1);

    // Stray ser_done outside HOLD
    reset = 1'b0; e_err = 1'b0; e_stall = 0;
    tick("rst2", 1'b0);
    reset = 1'b1;
    ser_done = 1'b1; tick("sd_stray", 1); e_err = 1'b1;
    tick("sd_check", 1);

    @(posedge clk); #1;
    @(posedge clk); #1;
    n_checks++;
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL pending_queue: got %0d entries expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
